// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 800x600@60 timing constants and phase encoding for the VGA timing block
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BACK   = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FRONT  = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 23;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  // Pin level for a sync signal given whether it is asserted and its polarity.
  function automatic logic sync_level(input logic asserted, input logic pos);
    return asserted ? pos : ~pos;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// rtl/vga_axis_timer.sv - one axis of the raster: phase FSM plus position counter
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK,
  parameter int W      = H_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic         wrap,
  output phase_e       phase,
  output logic [W-1:0] count
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [W-1:0] LAST_ACTIVE = W'(ACTIVE - 1);
  localparam logic [W-1:0] LAST_FRONT  = W'(ACTIVE + FRONT - 1);
  localparam logic [W-1:0] LAST_SYNC   = W'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [W-1:0] LAST        = W'(TOTAL - 1);

  phase_e       phase_next;
  logic [W-1:0] count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_ACTIVE;
      count <= '0;
    end else begin
      phase <= phase_next;
      count <= count_next;
    end
  end

  // Phase boundaries are absolute count values, so the phase and count never drift apart.
  always_comb begin
    phase_next = phase;
    count_next = count;
    wrap       = 1'b0;
    if (step) begin
      count_next = count + W'(1);
      unique case (phase)
        PH_ACTIVE: if (count == LAST_ACTIVE) phase_next = PH_FRONT;
        PH_FRONT:  if (count == LAST_FRONT)  phase_next = PH_SYNC;
        PH_SYNC:   if (count == LAST_SYNC)   phase_next = PH_BACK;
        PH_BACK: begin
          if (count == LAST) begin
            phase_next = PH_ACTIVE;
            count_next = '0;
            wrap       = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster timing with registered syncs, coordinates and per-frame update window
// Optional frame-overrun detection (tear output) is built when TEAR_DETECT_EN is defined.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int SYNC_POS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       update_go,
`ifdef TEAR_DETECT_EN
  input  logic       update_busy,
  output logic       tear
`else
  input  logic       update_busy
`endif
);

  localparam logic SYNC_ON = (SYNC_POS != 0);
  localparam logic [V_CNT_W-1:0] V_FRONT_ENTRY = V_CNT_W'(V_ACTIVE);

  logic               h_wrap;
  logic               v_wrap;
  phase_e             h_phase;
  phase_e             v_phase;
  logic [H_CNT_W-1:0] hcnt;
  logic [V_CNT_W-1:0] vcnt;
  logic               in_active;
  logic               line_begin;

  vga_axis_timer #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(H_CNT_W)
  ) u_h_timer (
    .clk   (clk),
    .rst   (rst),
    .step  (ce),
    .wrap  (h_wrap),
    .phase (h_phase),
    .count (hcnt)
  );

  vga_axis_timer #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(V_CNT_W)
  ) u_v_timer (
    .clk   (clk),
    .rst   (rst),
    .step  (ce & h_wrap),
    .wrap  (v_wrap),
    .phase (v_phase),
    .count (vcnt)
  );

  assign in_active  = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  assign line_begin = (hcnt == '0);

  // Outputs are a one-cycle registered image of the counters; pulses drop whenever ce is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync      <= ~SYNC_ON;
      vsync      <= ~SYNC_ON;
      active     <= 1'b0;
      x          <= '0;
      y          <= '0;
      line_start <= 1'b0;
      update_go  <= 1'b0;
    end else if (ce) begin
      hsync      <= sync_level(h_phase == PH_SYNC, SYNC_ON);
      vsync      <= sync_level(v_phase == PH_SYNC, SYNC_ON);
      active     <= in_active;
      x          <= in_active ? hcnt[9:0] : '0;
      y          <= in_active ? vcnt : '0;
      line_start <= line_begin;
      update_go  <= line_begin && (vcnt == V_FRONT_ENTRY);
    end else begin
      line_start <= 1'b0;
      update_go  <= 1'b0;
    end
  end

`ifdef TEAR_DETECT_EN
  logic frame_begin;
  logic unused_wrap;
  assign frame_begin = line_begin && (vcnt == '0);
  assign unused_wrap = v_wrap;

  // Game logic still busy when the next frame starts means it overran its window.
  always_ff @(posedge clk) begin
    if (rst) begin
      tear <= 1'b0;
    end else if (ce && frame_begin && update_busy) begin
      tear <= 1'b1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = update_busy ^ v_wrap;
`endif

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

- Generates 800x600@60 Hz VGA timing: sync pulses, active-video flag and pixel coordinates.
- Sequences the horizontal/vertical position counters through active, front-porch, sync and back-porch phases.
- Sits between the 40 MHz pixel clock domain and the renderer/game logic.
- Schedules one game-logic update window per frame, in vertical blanking.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch (clocks)
- H_SYNC, 128, hsync width (clocks)
- H_BACK, 88, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BACK, 23, vertical back porch (lines)
- SYNC_POS, 1, 1 = sync asserted high, 0 = sync asserted low

Ports:
- clk, in, 1, pixel clock; single clock domain
- rst, in, 1, synchronous, active-high reset
- ce, in, 1, pixel enable; counters advance only when high
- hsync, out, 1, horizontal sync, polarity per SYNC_POS
- vsync, out, 1, vertical sync, polarity per SYNC_POS
- active, out, 1, high while both axes are in their active phase
- x, out, 10, pixel column 0..H_ACTIVE-1 when active, else 0
- y, out, 10, pixel row 0..V_ACTIVE-1 when active, else 0
- line_start, out, 1, one-cycle pulse at x=0 of every line, active or blank
- update_go, out, 1, one-cycle pulse on entry to vertical front porch
- update_busy, in, 1, game logic is busy with an update
- tear, out, 1, sticky frame-overrun flag (only when TEAR_DETECT_EN is defined)

## Operation
- Internal counters: hcnt (11 bit, 0..1055) and vcnt (10 bit, 0..627). Totals are the sum of the four phases of each axis.
- Horizontal FSM: H_ACTIVE -> H_FRONT -> H_SYNC -> H_BACK -> H_ACTIVE. Each transition occurs when the phase count reaches its parameter.
- hcnt wraps to 0 at H_TOTAL-1.
- Vertical FSM: V_ACTIVE -> V_FRONT -> V_SYNC -> V_BACK -> V_ACTIVE. It advances only on the ce cycle where hcnt wraps.
- vcnt wraps to 0 at V_TOTAL-1, together with the hcnt wrap.
- ce low freezes all counters and FSMs and holds every output.
- Pulse outputs (line_start, update_go) are forced low while ce is low.
- hsync is asserted only in H_SYNC; vsync is asserted only in V_SYNC.
- active = (H state is H_ACTIVE) and (V state is V_ACTIVE).
- x and y are forced to 0 outside active.
- update_go fires exactly once per frame, on the cycle the V FSM enters V_FRONT (hcnt=0, vcnt=V_ACTIVE).
- update_busy is sampled only on the cycle the V FSM returns to V_ACTIVE (frame start).
- Reset values: hcnt=0, vcnt=0, both FSMs in ACTIVE; hsync and vsync deasserted; active=0; x=0, y=0; line_start=0, update_go=0, tear=0.
- rst mid-frame has the same effect as power-up reset, with no partial-line completion.

## Timing
- All outputs are registered and lag the internal counters by exactly 1 cycle.
- First cycle after rst deasserts (ce=1): counters at (0,0).
- Next cycle: active=1, x=0, y=0, line_start=1.
- Line period is 1056 ce-cycles. Frame period is 1056*628 = 663,168 ce-cycles.
- hsync is asserted for ce-cycles with hcnt in 840..967.
- vsync is asserted for lines 601..604.
- rst and ce high together: rst wins.
- Frame-start and update_busy high together: tear is set on that cycle (when TEAR_DETECT_EN is defined).

## Configuration
- TEAR_DETECT_EN defined:
  - tear port exists.
  - tear sets when update_busy=1 at frame start.
  - tear clears only on rst.
- TEAR_DETECT_EN undefined:
  - tear port and its register are absent.
  - update_busy is ignored.

## Structure
- Package vga_timing_pkg holds:
  - default timing constants and derived H_TOTAL/V_TOTAL
  - 2-bit phase enum: PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK
- Sub-module vga_axis_timer is instantiated twice (horizontal, vertical):
  - phase FSM plus counter
  - inputs: step enable
  - outputs: wrap pulse, phase, count

## Test plan
- rst for 3 cycles, then ce=1 -> one cycle later active=1, x=0, y=0, line_start=1; hsync and vsync deasserted.
- Run 1056 ce-cycles -> active falls after x=799; hsync asserted for exactly 128 cycles; line_start repeats at cycle 1056 with y=1.
- Run a full frame -> update_go pulses exactly once, at vcnt=600, hcnt=0; vsync asserted for 4*1056 cycles; frame wraps to (0,0) at cycle 663,168.
- Toggle ce with 50% duty -> output sequence is identical to the ce=1 run with each step stretched; no pulse lasts more than one cycle.
- update_busy held high across frame start -> tear=1 and remains 1; update_busy low at the next frame start -> tear stays 1 until rst (macro defined).
- Assert rst at hcnt=500, vcnt=300 -> next cycle all outputs at reset values; restart matches the first scenario.
